// File: rtl/sgd_gradient_bitserial_acc.sv
// sgd_gradient_bitserial_acc: bit-serial per-lane gradient accumulator.
// Define SGD_GRAD_ROUND_EN for round-half-up output instead of floor.
module sgd_gradient_bitserial_acc #(
   parameter int NUM_BANKS  = 8,
   parameter int NUM_LANES  = 64,
   parameter int MAX_BITS   = 16,
   parameter int GUARD_BITS = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           started,
   input  logic [31:0]                    dimension,
   input  logic [5:0]                     number_of_bits,
   input  logic [32*NUM_BANKS-1:0]        loss_in,
   input  logic                           loss_valid,
   output logic                           loss_ready,
   input  logic                           fifo_a_empty,
   output logic                           fifo_a_rd_en,
   input  logic [NUM_LANES*NUM_BANKS-1:0] fifo_a_rd_data,
   output logic [32*NUM_LANES-1:0]        grad_out,
   output logic                           grad_valid,
   output logic [15:0]                    grad_chunk_idx,
   output logic                           busy,
   output logic                           done
);

   localparam int TREE_D = $clog2(NUM_BANKS);
   localparam int TW     = 32 + TREE_D;
   localparam int ACC_W  = TW + GUARD_BITS;
   localparam int QW     = ACC_W + 1 - GUARD_BITS;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t             state;
   logic [31:0]        chunks_q;
   logic [5:0]         nb_q;
   logic [32:0]        dim_ext;
   logic [31:0]        chunk;
   logic [5:0]         plane;
   logic signed [31:0] loss_q [NUM_BANKS];
   logic               pop;
   logic               last_plane;
   logic               any_valid;

   logic               v0, v1, sv, av;
   logic [TREE_D:0]    tv;
   logic [5:0]         p0_plane, s1_plane, s_plane;
   logic               p0_last, s1_last, s_last, a_last;
   logic [15:0]        p0_chunk, s1_chunk, s_chunk, a_chunk;
   logic [NUM_LANES*NUM_BANKS-1:0] s1_data;
   logic [5:0]         tp [TREE_D+1];
   logic               tl [TREE_D+1];
   logic [15:0]        tc [TREE_D+1];
   logic signed [TW-1:0]    tr [TREE_D+1][NUM_LANES][NUM_BANKS];
   logic signed [ACC_W-1:0] sh [NUM_LANES];
   logic signed [ACC_W-1:0] acc [NUM_LANES];
   logic [6:0]         shamt;
   logic [ACC_W:0]     rnd [NUM_LANES];
   logic [QW-1:0]      q [NUM_LANES];
   logic [31:0]        sat [NUM_LANES];

`ifdef SGD_GRAD_ROUND_EN
   localparam logic [ACC_W:0] RND_K = (ACC_W+1)'(1) << (GUARD_BITS - 1);
`endif

   assign dim_ext    = {1'b0, dimension} + 33'(NUM_LANES - 1);
   assign pop        = started & (state == RUN) & ~fifo_a_empty;
   assign last_plane = (plane >= nb_q - 6'd1);
   assign any_valid  = v0 | v1 | (|tv) | sv | av;
   assign busy       = (state != IDLE) | any_valid;
   assign loss_ready = rst_n & started & (state == IDLE);
   assign fifo_a_rd_en = pop;
   assign shamt      = 7'(tp[TREE_D]) + 7'd1;

   // Chunk count and clamped plane count, refreshed every cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chunks_q <= '0;
         nb_q     <= 6'd1;
      end else begin
         chunks_q <= 32'(dim_ext / 33'(NUM_LANES));
         if (number_of_bits == 6'd0)
            nb_q <= 6'd1;
         else if (int'(number_of_bits) > MAX_BITS)
            nb_q <= 6'(MAX_BITS);
         else
            nb_q <= number_of_bits;
      end
   end

   // Sequencer: sample handshake, plane/chunk walk, drain and abort
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         chunk <= '0;
         plane <= '0;
         done  <= 1'b0;
         for (int b = 0; b < NUM_BANKS; b++)
            loss_q[b] <= '0;
      end else begin
         done <= 1'b0;
         if (!started) begin
            state <= IDLE;
         end else begin
            unique case (state)
               IDLE: begin
                  if (loss_valid) begin
                     for (int b = 0; b < NUM_BANKS; b++)
                        loss_q[b] <= loss_in[32*b +: 32];
                     chunk <= '0;
                     plane <= '0;
                     state <= (chunks_q == 32'd0) ? DRAIN : RUN;
                  end
               end
               RUN: begin
                  if (!fifo_a_empty) begin
                     if (last_plane) begin
                        plane <= '0;
                        chunk <= chunk + 32'd1;
                        if (chunk == chunks_q - 32'd1)
                           state <= DRAIN;
                     end else begin
                        plane <= plane + 6'd1;
                     end
                  end
               end
               DRAIN: begin
                  if (!any_valid) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Stage valids; an abort flushes them all in one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0 <= 1'b0;
         v1 <= 1'b0;
         tv <= '0;
         sv <= 1'b0;
         av <= 1'b0;
         grad_valid <= 1'b0;
      end else if (!started) begin
         v0 <= 1'b0;
         v1 <= 1'b0;
         tv <= '0;
         sv <= 1'b0;
         av <= 1'b0;
         grad_valid <= 1'b0;
      end else begin
         v0 <= pop;
         v1 <= v0;
         tv <= {tv[TREE_D-1:0], v1};
         sv <= tv[TREE_D];
         av <= sv;
         grad_valid <= av & a_last;
      end
   end

   // Datapath with plane/last/chunk tags riding alongside the data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p0_plane <= '0; p0_last <= 1'b0; p0_chunk <= '0;
         s1_plane <= '0; s1_last <= 1'b0; s1_chunk <= '0;
         s_plane  <= '0; s_last  <= 1'b0; s_chunk  <= '0;
         a_last   <= 1'b0; a_chunk <= '0;
         s1_data  <= '0;
         grad_out <= '0;
         grad_chunk_idx <= '0;
         for (int k = 0; k <= TREE_D; k++) begin
            tp[k] <= '0; tl[k] <= 1'b0; tc[k] <= '0;
            for (int l = 0; l < NUM_LANES; l++)
               for (int n = 0; n < NUM_BANKS; n++)
                  tr[k][l][n] <= '0;
         end
         for (int l = 0; l < NUM_LANES; l++) begin
            sh[l]  <= '0;
            acc[l] <= '0;
         end
      end else begin
         p0_plane <= plane;
         p0_last  <= last_plane;
         p0_chunk <= chunk[15:0];
         s1_plane <= p0_plane;
         s1_last  <= p0_last;
         s1_chunk <= p0_chunk;
         s1_data  <= fifo_a_rd_data;
         tp[0] <= s1_plane;
         tl[0] <= s1_last;
         tc[0] <= s1_chunk;
         for (int l = 0; l < NUM_LANES; l++)
            for (int b = 0; b < NUM_BANKS; b++)
               tr[0][l][b] <= s1_data[l + b*NUM_LANES] ?
                              TW'(loss_q[b]) : '0;
         for (int k = 1; k <= TREE_D; k++) begin
            tp[k] <= tp[k-1];
            tl[k] <= tl[k-1];
            tc[k] <= tc[k-1];
            for (int l = 0; l < NUM_LANES; l++) begin
               for (int n = 0; n < NUM_BANKS/2; n++)
                  tr[k][l][n] <= tr[k-1][l][2*n] + tr[k-1][l][2*n+1];
               for (int n = NUM_BANKS/2; n < NUM_BANKS; n++)
                  tr[k][l][n] <= '0;
            end
         end
         s_plane <= tp[TREE_D];
         s_last  <= tl[TREE_D];
         s_chunk <= tc[TREE_D];
         for (int l = 0; l < NUM_LANES; l++)
            sh[l] <= $signed({tr[TREE_D][l][0],
                              {GUARD_BITS{1'b0}}}) >>> shamt;
         if (sv) begin
            a_last  <= s_last;
            a_chunk <= s_chunk;
            for (int l = 0; l < NUM_LANES; l++)
               acc[l] <= (s_plane == 6'd0) ? sh[l] : acc[l] + sh[l];
         end
         if (av & a_last) begin
            grad_chunk_idx <= a_chunk;
            for (int l = 0; l < NUM_LANES; l++)
               grad_out[32*l +: 32] <= sat[l];
         end
      end
   end

   // Drop guard bits (floor, or round half up) and clamp to 32 bits
   always_comb begin
      for (int l = 0; l < NUM_LANES; l++) begin
`ifdef SGD_GRAD_ROUND_EN
         rnd[l] = {acc[l][ACC_W-1], acc[l]} + RND_K;
`else
         rnd[l] = {acc[l][ACC_W-1], acc[l]};
`endif
         q[l] = rnd[l][ACC_W:GUARD_BITS];
         if ((&q[l][QW-1:31]) | ~(|q[l][QW-1:31]))
            sat[l] = q[l][31:0];
         else if (q[l][QW-1])
            sat[l] = 32'h8000_0000;
         else
            sat[l] = 32'h7FFF_FFFF;
      end
   end

endmodule
